// File: rtl/laser_search_sched.sv
// ============================================================================
// laser_search_sched
//
// Sequencing controller for the two-circle laser coverage search.
//
// The controller runs an alternating hill climb. In each round, circle 1 is
// refined first and then circle 2. During a circle's phase the controller
// evaluates the committed centre (BASE) and then its four neighbours
// (UP, DOWN, LEFT, RIGHT). Each evaluation goes to a shared external
// coverage-count unit over a REQ/ACK handshake. The best strictly-improving
// neighbour is then committed.
//
// The search ends in either of two cases:
//   - a whole round produces no move, or
//   - MAXITER rounds have been completed.
// At the end, DONE pulses for one cycle and the committed centres are final.
//
// Parameters
//   NPTS      number of points the coverage unit counts (sets EVAL_CNT width)
//   MAXITER   maximum number of rounds (circle-1 phase + circle-2 phase)
//
// Ports
//   CLK                  clock, rising edge
//   RST                  asynchronous active-high reset
//   START                one-cycle pulse, begins a search (ignored while BUSY)
//   INIT_X, INIT_Y       seed centre loaded into both circles on START
//   EVAL_REQ             candidate pair valid, held until EVAL_ACK
//   CAND_X1..CAND_Y2     candidate centres presented with EVAL_REQ
//   EVAL_ACK             one-cycle acknowledge, EVAL_CNT valid with it
//   EVAL_CNT             points covered by the candidate pair
//   C1X, C1Y, C2X, C2Y   committed centres
//   BUSY                 search in progress
//   DONE                 one-cycle pulse, search finished
// ============================================================================
module laser_search_sched #(
    parameter int NPTS    = 40,
    parameter int MAXITER = 8,
    localparam int CNT_W  = $clog2(NPTS + 1),
    localparam int RND_W  = $clog2(MAXITER + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       INIT_X,
    input  logic [3:0]       INIT_Y,
    output logic             EVAL_REQ,
    output logic [3:0]       CAND_X1,
    output logic [3:0]       CAND_Y1,
    output logic [3:0]       CAND_X2,
    output logic [3:0]       CAND_Y2,
    input  logic             EVAL_ACK,
    input  logic [CNT_W-1:0] EVAL_CNT,
    output logic [3:0]       C1X,
    output logic [3:0]       C1Y,
    output logic [3:0]       C2X,
    output logic [3:0]       C2Y,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        COMMIT,
        SWITCH,
        FINISH
    } state_t;

    typedef enum logic [2:0] {
        DIR_BASE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t           state;
    dir_t             dir;
    dir_t             best_dir;
    logic [CNT_W-1:0] best_cnt;
    logic [3:0]       best_x;
    logic [3:0]       best_y;
    logic [RND_W-1:0] round;
    logic             active2;
    logic             moved_flag;

    logic [3:0]       act_x;
    logic [3:0]       act_y;
    logic [3:0]       cur_x;
    logic [3:0]       cur_y;
    logic             nxt_found;
    dir_t             nxt_dir;
    logic [RND_W-1:0] round_next;

    // Neighbour coordinates are formed in 5 bits. Both 0-1 and 15+1 set
    // bit 4, so an off-grid neighbour is flagged rather than wrapped.
    function automatic logic [9:0] nb_raw(input dir_t d,
                                          input logic [3:0] x,
                                          input logic [3:0] y);
        logic [4:0] nx;
        logic [4:0] ny;
        nx = {1'b0, x};
        ny = {1'b0, y};
        case (d)
            DIR_UP:    ny = ny + 5'd1;
            DIR_DOWN:  ny = ny - 5'd1;
            DIR_LEFT:  nx = nx - 5'd1;
            DIR_RIGHT: nx = nx + 5'd1;
            default:   ;
        endcase
        return {nx, ny};
    endfunction

    // True when the neighbour in direction d stays inside 0..15 on both axes.
    function automatic logic nb_ok(input dir_t d,
                                   input logic [3:0] x,
                                   input logic [3:0] y);
        logic [9:0] r;
        r = nb_raw(d, x, y);
        return ~(r[9] | r[4]);
    endfunction

    // Returns the in-range candidate coordinates as {x, y}.
    function automatic logic [7:0] nb_xy(input dir_t d,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
        logic [9:0] r;
        r = nb_raw(d, x, y);
        return {r[8:5], r[3:0]};
    endfunction

    // Committed centre of the circle currently being refined, and the
    // candidate for the current direction around it. The centre does not
    // change during a phase, so cur_x/cur_y stay stable through WAIT.
    always_comb begin
        act_x = active2 ? C2X : C1X;
        act_y = active2 ? C2Y : C1Y;
        {cur_x, cur_y} = nb_xy(dir, act_x, act_y);
        round_next = round + RND_W'(1);
    end

    // Finds the first in-range direction after the current one in the fixed
    // order UP, DOWN, LEFT, RIGHT. No match means the phase is over.
    always_comb begin
        nxt_found = 1'b0;
        nxt_dir   = DIR_BASE;
        for (int i = 1; i <= 4; i++) begin
            if (!nxt_found && (3'(i) > dir) && nb_ok(dir_t'(3'(i)), act_x, act_y)) begin
                nxt_found = 1'b1;
                nxt_dir   = dir_t'(3'(i));
            end
        end
    end

    // Main sequencer. All outputs are registered here.
    // The candidate lines are loaded in ISSUE and then left untouched until
    // the next ISSUE, so they stay stable for as long as EVAL_REQ is high.
    // ACK is only examined in WAIT, which is the only state where EVAL_REQ
    // is high, so stray acknowledges in other states have no effect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            dir        <= DIR_BASE;
            best_dir   <= DIR_BASE;
            best_cnt   <= '0;
            best_x     <= 4'd0;
            best_y     <= 4'd0;
            round      <= '0;
            active2    <= 1'b0;
            moved_flag <= 1'b0;
            EVAL_REQ   <= 1'b0;
            CAND_X1    <= 4'd0;
            CAND_Y1    <= 4'd0;
            CAND_X2    <= 4'd0;
            CAND_Y2    <= 4'd0;
            C1X        <= 4'd0;
            C1Y        <= 4'd0;
            C2X        <= 4'd0;
            C2Y        <= 4'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        C1X        <= INIT_X;
                        C1Y        <= INIT_Y;
                        C2X        <= INIT_X;
                        C2Y        <= INIT_Y;
                        round      <= '0;
                        active2    <= 1'b0;
                        moved_flag <= 1'b0;
                        dir        <= DIR_BASE;
                        BUSY       <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    EVAL_REQ <= 1'b1;
                    if (active2) begin
                        CAND_X1 <= C1X;
                        CAND_Y1 <= C1Y;
                        CAND_X2 <= cur_x;
                        CAND_Y2 <= cur_y;
                    end else begin
                        CAND_X1 <= cur_x;
                        CAND_Y1 <= cur_y;
                        CAND_X2 <= C2X;
                        CAND_Y2 <= C2Y;
                    end
                    state <= WAIT;
                end

                WAIT: begin
                    if (EVAL_ACK) begin
                        EVAL_REQ <= 1'b0;
                        if ((dir == DIR_BASE) || (EVAL_CNT > best_cnt)) begin
                            best_cnt <= EVAL_CNT;
                            best_dir <= dir;
                            best_x   <= cur_x;
                            best_y   <= cur_y;
                        end
                        state <= NEXT;
                    end
                end

                NEXT: begin
                    if (nxt_found) begin
                        dir   <= nxt_dir;
                        state <= ISSUE;
                    end else begin
                        state <= COMMIT;
                    end
                end

                COMMIT: begin
                    if (best_dir != DIR_BASE) begin
                        if (active2) begin
                            C2X <= best_x;
                            C2Y <= best_y;
                        end else begin
                            C1X <= best_x;
                            C1Y <= best_y;
                        end
                        moved_flag <= 1'b1;
                    end
                    state <= SWITCH;
                end

                SWITCH: begin
                    dir <= DIR_BASE;
                    if (!active2) begin
                        active2 <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        round <= round_next;
                        if (!moved_flag || (round_next == RND_W'(MAXITER))) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            moved_flag <= 1'b0;
                            active2    <= 1'b0;
                            state      <= ISSUE;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_search_sched.sv
// ============================================================================
// tb_laser_search_sched
//
// Self-checking bench for laser_search_sched.
//
// The stimulus tasks do two things before each search:
//   - push the hand-derived candidate sequence into exp_req, and
//   - push the final centres into exp_final.
//
// A monitor process compares the DUT against these queues:
//   - on every new request it checks the candidate lines;
//   - in every further cycle of that request it checks that the candidate
//     lines have not changed;
//   - on DONE it checks the committed centres.
//
// A responder process acknowledges requests with a count chosen by the
// scenario. It can optionally add random stalls and stray acknowledges.
// ============================================================================
module tb_laser_search_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] INIT_X;
    logic [3:0] INIT_Y;
    logic       EVAL_REQ;
    logic [3:0] CAND_X1;
    logic [3:0] CAND_Y1;
    logic [3:0] CAND_X2;
    logic [3:0] CAND_Y2;
    logic       EVAL_ACK;
    logic [5:0] EVAL_CNT;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       BUSY;
    logic       DONE;

    typedef logic [15:0] quad_t;

    quad_t exp_req[$];
    quad_t exp_final[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    resp_mode   = 0;
    logic [5:0] flat_val = 6'd0;
    bit    stall_en    = 1'b0;
    int    phase_pos   = 0;
    int    delay_left  = 0;
    bit    ack_done    = 1'b0;
    bit    prev_req    = 1'b0;
    quad_t held        = 16'h0;

    // 100 MHz style free-running clock.
    always #5 CLK = ~CLK;

    laser_search_sched #(
        .NPTS    (40),
        .MAXITER (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .INIT_X   (INIT_X),
        .INIT_Y   (INIT_Y),
        .EVAL_REQ (EVAL_REQ),
        .CAND_X1  (CAND_X1),
        .CAND_Y1  (CAND_Y1),
        .CAND_X2  (CAND_X2),
        .CAND_Y2  (CAND_Y2),
        .EVAL_ACK (EVAL_ACK),
        .EVAL_CNT (EVAL_CNT),
        .C1X      (C1X),
        .C1Y      (C1Y),
        .C2X      (C2X),
        .C2Y      (C2Y),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    // Records one comparison and reports it on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Coverage count returned by the fake coverage unit for the scenario:
    //   1 = flat field,
    //   2 = single peak at CAND1=(7,8),
    //   3 = count rising with position inside the phase.
    function automatic logic [5:0] resp_count();
        case (resp_mode)
            1:       return flat_val;
            2:       return (CAND_X1 == 4'd7 && CAND_Y1 == 4'd8) ? 6'd12 : 6'd10;
            default: return 6'(10 + phase_pos);
        endcase
    endfunction

    // Pushes the five requests of a circle-1 phase around (cx,cy).
    // Circle 2 stays parked at (ox,oy) throughout.
    task automatic push_phase1(input int cx, input int cy, input int ox, input int oy);
        exp_req.push_back({4'(cx),     4'(cy),     4'(ox), 4'(oy)});
        exp_req.push_back({4'(cx),     4'(cy + 1), 4'(ox), 4'(oy)});
        exp_req.push_back({4'(cx),     4'(cy - 1), 4'(ox), 4'(oy)});
        exp_req.push_back({4'(cx - 1), 4'(cy),     4'(ox), 4'(oy)});
        exp_req.push_back({4'(cx + 1), 4'(cy),     4'(ox), 4'(oy)});
    endtask

    // Pushes the five requests of a circle-2 phase around (cx,cy).
    // Circle 1 stays parked at (ox,oy) throughout.
    task automatic push_phase2(input int cx, input int cy, input int ox, input int oy);
        exp_req.push_back({4'(ox), 4'(oy), 4'(cx),     4'(cy)});
        exp_req.push_back({4'(ox), 4'(oy), 4'(cx),     4'(cy + 1)});
        exp_req.push_back({4'(ox), 4'(oy), 4'(cx),     4'(cy - 1)});
        exp_req.push_back({4'(ox), 4'(oy), 4'(cx - 1), 4'(cy)});
        exp_req.push_back({4'(ox), 4'(oy), 4'(cx + 1), 4'(cy)});
    endtask

    // Responder: acknowledges each request once, after an optional random
    // stall. While no request is pending it may fire stray acknowledges that
    // carry a bogus count.
    initial begin
        EVAL_ACK = 1'b0;
        EVAL_CNT = 6'd0;
        forever begin
            @(posedge CLK);
            #1;
            EVAL_ACK = 1'b0;
            if (resp_mode != 0 && EVAL_REQ && !ack_done) begin
                if (delay_left > 0) begin
                    delay_left--;
                end else begin
                    EVAL_ACK  = 1'b1;
                    EVAL_CNT  = resp_count();
                    ack_done  = 1'b1;
                    phase_pos = (phase_pos + 1) % 5;
                end
            end else if (!EVAL_REQ) begin
                ack_done   = 1'b0;
                delay_left = stall_en ? int'($urandom_range(0, 7)) : 0;
                if (stall_en && $urandom_range(0, 2) == 0) begin
                    EVAL_ACK = 1'b1;
                    EVAL_CNT = 6'd63;
                end
            end
        end
    end

    // Monitor: the scoreboard side.
    //   - On a rising EVAL_REQ it compares the candidates against the
    //     expected queue.
    //   - While the request is held it checks candidate stability.
    //   - On DONE it checks the final centres and that every expected
    //     request was issued.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (!RST) begin
                if (EVAL_REQ && !prev_req) begin
                    if (exp_req.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_req: got request %0h, expected no request",
                                 {CAND_X1, CAND_Y1, CAND_X2, CAND_Y2});
                        held = {CAND_X1, CAND_Y1, CAND_X2, CAND_Y2};
                    end else begin
                        held = exp_req.pop_front();
                        checkOutput("cand", 32'({CAND_X1, CAND_Y1, CAND_X2, CAND_Y2}), 32'(held));
                    end
                end else if (EVAL_REQ) begin
                    checkOutput("cand_stable", 32'({CAND_X1, CAND_Y1, CAND_X2, CAND_Y2}), 32'(held));
                end
                if (DONE) begin
                    if (exp_final.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_done: got DONE=1, expected DONE=0");
                    end else begin
                        checkOutput("final_centres", 32'({C1X, C1Y, C2X, C2Y}), 32'(exp_final.pop_front()));
                    end
                    checkOutput("busy_at_done", 32'(BUSY), 32'd0);
                    checkOutput("reqs_left_at_done", 32'(exp_req.size()), 32'd0);
                end
            end
            prev_req = EVAL_REQ;
        end
    end

    // Starts one search and waits, within a bounded number of cycles, for
    // DONE. Partway through, it also fires a START while BUSY with a
    // different seed; that pulse must be ignored.
    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input int mode,
                                 input logic [5:0] fv, input bit stall);
        int cycles;
        resp_mode = mode;
        flat_val  = fv;
        stall_en  = stall;
        phase_pos = 0;
        @(negedge CLK);
        INIT_X = x;
        INIT_Y = y;
        START  = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checkOutput("busy_after_start", 32'(BUSY), 32'd1);
        checkOutput("req_after_start", 32'(EVAL_REQ), 32'd0);
        repeat (3) @(negedge CLK);
        INIT_X = 4'd3;
        INIT_Y = 4'd3;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        cycles = 0;
        while (!DONE && cycles < 5000) begin
            @(negedge CLK);
            cycles++;
        end
        if (!DONE) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no DONE in %0d cycles, expected DONE", cycles);
        end else begin
            @(negedge CLK);
            checkOutput("done_pulse_width", 32'(DONE), 32'd0);
        end
        repeat (6) @(negedge CLK);
        stall_en  = 1'b0;
        resp_mode = 0;
    endtask

    initial begin
        int cycles;
        RST    = 1'b1;
        START  = 1'b0;
        INIT_X = 4'd0;
        INIT_Y = 4'd0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_outputs",
                    32'({EVAL_REQ, CAND_X1, CAND_Y1, CAND_X2, CAND_Y2, C1X, C1Y, C2X, C2Y, BUSY, DONE}),
                    32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] flat field at (7,7)");
        push_phase1(7, 7, 7, 7);
        push_phase2(7, 7, 7, 7);
        exp_final.push_back({4'd7, 4'd7, 4'd7, 4'd7});
        applyStimulus(4'd7, 4'd7, 1, 6'd10, 1'b0);

        $display("[TB] single peak at CAND1=(7,8)");
        push_phase1(7, 7, 7, 7);
        push_phase2(7, 7, 7, 8);
        push_phase1(7, 8, 7, 7);
        push_phase2(7, 7, 7, 8);
        exp_final.push_back({4'd7, 4'd8, 4'd7, 4'd7});
        applyStimulus(4'd7, 4'd7, 2, 6'd0, 1'b0);

        $display("[TB] corner skip at (0,15)");
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd14, 4'd0, 4'd15});
        exp_req.push_back({4'd1, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd14});
        exp_req.push_back({4'd0, 4'd15, 4'd1, 4'd15});
        exp_final.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        applyStimulus(4'd0, 4'd15, 1, 6'd5, 1'b0);

        $display("[TB] round cap from (2,2)");
        for (int r = 0; r < 8; r++) begin
            push_phase1(2 + r, 2, 2 + r, 2);
            push_phase2(2 + r, 2, 3 + r, 2);
        end
        exp_final.push_back({4'd10, 4'd2, 4'd10, 4'd2});
        applyStimulus(4'd2, 4'd2, 3, 6'd0, 1'b0);

        $display("[TB] single peak with stalls and stray acks");
        push_phase1(7, 7, 7, 7);
        push_phase2(7, 7, 7, 8);
        push_phase1(7, 8, 7, 7);
        push_phase2(7, 7, 7, 8);
        exp_final.push_back({4'd7, 4'd8, 4'd7, 4'd7});
        applyStimulus(4'd7, 4'd7, 2, 6'd0, 1'b1);

        $display("[TB] reset while a request is pending");
        resp_mode = 0;
        exp_req.push_back({4'd7, 4'd7, 4'd7, 4'd7});
        @(negedge CLK);
        INIT_X = 4'd7;
        INIT_Y = 4'd7;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        cycles = 0;
        while (!EVAL_REQ && cycles < 20) begin
            @(negedge CLK);
            cycles++;
        end
        checkOutput("req_before_reset", 32'(EVAL_REQ), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort_outputs",
                    32'({EVAL_REQ, CAND_X1, CAND_Y1, CAND_X2, CAND_Y2, C1X, C1Y, C2X, C2Y, BUSY, DONE}),
                    32'd0);
        exp_req.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        checkOutput("req_after_reset", 32'({EVAL_REQ, BUSY}), 32'd0);

        $display("[TB] corner skip again after reset");
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd14, 4'd0, 4'd15});
        exp_req.push_back({4'd1, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        exp_req.push_back({4'd0, 4'd15, 4'd0, 4'd14});
        exp_req.push_back({4'd0, 4'd15, 4'd1, 4'd15});
        exp_final.push_back({4'd0, 4'd15, 4'd0, 4'd15});
        applyStimulus(4'd0, 4'd15, 1, 6'd5, 1'b0);

        checkOutput("final_queue_empty", 32'(exp_final.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
